// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared opcodes, FSM states and frame sizing for the configuration loader.
package fpga_cfg_pkg;
   localparam logic [1:0] OP_TILE = 2'b00;
   localparam logic [1:0] OP_SBOX = 2'b01;
   localparam logic [1:0] OP_END  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;
   localparam int TILE_BYTES = 5;
   localparam int SBOX_BYTES = 2;
   localparam logic [5:0] SBOX_BASE = 6'd32;
   typedef enum logic [2:0] {S_HDR, S_PAYLOAD, S_CHECK, S_COMMIT, S_DONE, S_ERROR} state_t;
endpackage

// File: rtl/cfg_frame_assembler.sv
// cfg_frame_assembler: payload byte counter, little-endian word assembly and running XOR checksum.
module cfg_frame_assembler (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic        shift,
   input  logic [7:0]  din,
   input  logic [2:0]  len,
   output logic [32:0] word,
   output logic [7:0]  csum,
   output logic        last
);
   logic [2:0] cnt;
   logic [2:0] pos;
   assign last = cnt == 3'd1;
   // Only bits 32:0 of the 40-bit payload are ever used, so the upper bits of byte 4 fall off the shift.
   always_ff @(posedge clock) begin
      if (reset) begin
         word <= '0;
         csum <= '0;
         cnt  <= '0;
         pos  <= '0;
      end else if (load) begin
         word <= '0;
         csum <= din;
         cnt  <= len;
         pos  <= '0;
      end else if (shift) begin
         word <= word | (33'(din) << {pos, 3'b000});
         csum <= csum ^ din;
         cnt  <= cnt - 3'd1;
         pos  <= pos + 3'd1;
      end
   end
endmodule

// File: rtl/fpga_config_loader.sv
// fpga_config_loader: checks framed configuration bytes and issues one fabric write per good frame.
import fpga_cfg_pkg::*;
module fpga_config_loader #(
   parameter int N_TILES = 22,
   parameter int N_SBOX  = 13
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        cfg_we,
   output logic [5:0]  cfg_addr,
   output logic [32:0] cfg_data,
   output logic        cfg_done,
   output logic        cfg_err,
   output logic        fabric_en,
   output logic [5:0]  frame_cnt
);
   state_t      state;
   logic [1:0]  op;
   logic [5:0]  idx;
   logic        take;
   logic        hdr_bad;
   logic [2:0]  len;
   logic [32:0] word;
   logic [7:0]  csum;
   logic        last;
   assign take = s_valid & s_ready;
   assign hdr_bad = s_data[7:6] == OP_RSVD ||
                    (s_data[7:6] == OP_TILE && int'(s_data[5:0]) >= N_TILES) ||
                    (s_data[7:6] == OP_SBOX && int'(s_data[5:0]) >= N_SBOX);
   assign len = s_data[7:6] == OP_TILE ? 3'(TILE_BYTES) :
                s_data[7:6] == OP_SBOX ? 3'(SBOX_BYTES) : 3'd0;
   cfg_frame_assembler u_asm (
      .clock (clock),
      .reset (reset),
      .load  (take && state == S_HDR),
      .shift (take && state == S_PAYLOAD),
      .din   (s_data),
      .len   (len),
      .word  (word),
      .csum  (csum),
      .last  (last)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_HDR;
         s_ready   <= 1'b1;
         cfg_we    <= 1'b0;
         cfg_addr  <= '0;
         cfg_data  <= '0;
         cfg_done  <= 1'b0;
         cfg_err   <= 1'b0;
         fabric_en <= 1'b0;
         frame_cnt <= '0;
         op        <= '0;
         idx       <= '0;
      end else begin
         cfg_we <= 1'b0;
         case (state)
            S_HDR: if (take) begin
               op  <= s_data[7:6];
               idx <= s_data[5:0];
               if (hdr_bad) begin
                  state   <= S_ERROR;
                  s_ready <= 1'b0;
                  cfg_err <= 1'b1;
               end else begin
                  state <= s_data[7:6] == OP_END ? S_CHECK : S_PAYLOAD;
               end
            end
            S_PAYLOAD: if (take && last) state <= S_CHECK;
            S_CHECK: if (take) begin
               s_ready <= 1'b0;
               if (s_data != csum) begin
                  state   <= S_ERROR;
                  cfg_err <= 1'b1;
               end else if (op == OP_END) begin
                  state     <= S_DONE;
                  cfg_done  <= 1'b1;
                  fabric_en <= 1'b1;
               end else begin
                  state     <= S_COMMIT;
                  cfg_we    <= 1'b1;
                  cfg_addr  <= op == OP_TILE ? idx : SBOX_BASE + idx;
                  cfg_data  <= op == OP_TILE ? word : {17'b0, word[15:0]};
                  frame_cnt <= frame_cnt == 6'd63 ? frame_cnt : frame_cnt + 6'd1;
               end
            end
            S_COMMIT: begin
               state   <= S_HDR;
               s_ready <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/fpga_config_loader.md
# fpga_config_loader

Byte-stream configuration controller for the FPGA fabric. It accepts framed configuration bytes over a valid/ready handshake, checks each frame, and issues one write strobe per good frame. Each write carries the configuration word for one logic tile (33-bit LUT/FF-select memory) or one 4x4 switch box (16-bit one-hot select). On an end-of-configuration frame it releases the fabric; any framing or checksum fault locks it in an error state until reset.

## Interface
Parameters:
- N_TILES, 22, number of logic tiles addressable (index 0..N_TILES-1)
- N_SBOX, 13, number of switch boxes addressable (index 0..N_SBOX-1)

Ports:
- clock  input  1  single system clock, all state updates on posedge
- reset  input  1  synchronous, active-high; one clock edge returns block to reset state
- s_data  input  8  configuration stream byte
- s_valid  input  1  s_data valid
- s_ready  output  1  loader accepts byte; transfer occurs on edge where s_valid & s_ready
- cfg_we  output  1  one-cycle write strobe to fabric configuration storage
- cfg_addr  output  6  target: tiles 0..21, switch boxes 32..(32+N_SBOX-1)
- cfg_data  output  33  configuration word, zero-extended for switch boxes
- cfg_done  output  1  configuration complete (sticky until reset)
- cfg_err  output  1  frame fault detected (sticky until reset)
- fabric_en  output  1  fabric may run; mirrors cfg_done
- frame_cnt  output  6  count of committed frames, saturates at 63

## Operation
- Frame = header byte, payload bytes (little-endian), checksum byte.
- Header: [7:6] opcode, [5:0] index. Opcodes: 00 tile write (5 payload bytes, bits 39:33 ignored), 01 switch-box write (2 payload bytes), 10 end (0 payload bytes, index ignored), 11 reserved.
- Checksum byte = XOR of header and all payload bytes.
- States: HDR, PAYLOAD, CHECK, COMMIT, DONE, ERROR.
- HDR: on accepted byte, latch opcode/index, clear running XOR to header value. Opcode 11, tile index >= N_TILES, or sbox index >= N_SBOX -> ERROR. Opcode 10 -> CHECK. Otherwise -> PAYLOAD with byte counter = 5 or 2.
- PAYLOAD: each accepted byte shifts into 40-bit assembly register at position 8*k, XORs into running checksum, decrements counter; last byte -> CHECK.
- CHECK: accepted byte compared with running XOR. Mismatch -> ERROR (no write). Match: end opcode -> DONE; else -> COMMIT.
- COMMIT: cfg_we=1 for exactly one cycle; cfg_addr = index (tile) or 32+index (sbox); cfg_data = assembly[32:0] or {17'b0, assembly[15:0]}; frame_cnt increments (saturating); -> HDR.
- DONE: cfg_done=1, fabric_en=1, s_ready=0; held until reset.
- ERROR: cfg_err=1, s_ready=0, fabric_en=0; held until reset.
- s_ready=1 in HDR, PAYLOAD, CHECK; 0 in COMMIT, DONE, ERROR.
- Bytes with s_valid=0 are ignored; state and counters hold across any number of idle cycles.

## Timing
- Reset values: state HDR, s_ready=1, cfg_we=0, cfg_addr=0, cfg_data=0, cfg_done=0, cfg_err=0, fabric_en=0, frame_cnt=0.
- Checksum byte accepted at edge N -> cfg_we high in cycle after N, low the following cycle.
- Error or done status visible the cycle after the offending or final byte is accepted.
- Throughput: tile frame 8 cycles (7 bytes + COMMIT), sbox frame 5 cycles, with s_valid held high.
- cfg_addr and cfg_data hold their last committed value outside COMMIT.
- Reset mid-frame discards the partial frame and issues no write; reset in DONE drops fabric_en the next cycle.
- Reset and s_valid on the same edge: reset wins; the byte is not consumed.

## Structure
- Package fpga_cfg_pkg: opcode constants (OP_TILE, OP_SBOX, OP_END, OP_RSVD), state enum, TILE_BYTES=5, SBOX_BYTES=2, SBOX_BASE=6'd32.
- One sub-module: cfg_frame_assembler. It holds the byte counter, 40-bit shift/assembly register and running XOR, with load/shift/clear controls from the FSM.

## Test plan
- Tile frame header 0x03, payload 0x11,0x22,0x33,0x44,0x01, checksum 0x03^0x11^0x22^0x33^0x44^0x01 -> single cfg_we, cfg_addr=3, cfg_data=33'h1_4433_2211, frame_cnt=1.
- Sbox frame header 0x45, payload 0x21,0x84, correct checksum -> cfg_addr=37, cfg_data=33'h0_8421.
- Bad checksum on tile frame -> no cfg_we; cfg_err=1 next cycle; s_ready=0; frame_cnt unchanged.
- Header 0x16 (tile 22) -> cfg_err=1 immediately after header; header 0xC0 -> cfg_err=1.
- Two good frames, then header 0x80 and checksum 0x80 -> cfg_done=1, fabric_en=1, s_ready=0, frame_cnt=2; s_valid bubbles inserted between bytes do not change results.
- Reset asserted after 3 payload bytes of a tile frame -> no cfg_we, all outputs at reset values; a following complete frame commits normally.
